// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and a per-grant hold limit.
// Optional ONEHOT_ARB_LOCK_EN adds a `lock` input that suppresses the hold timeout.
module onehot_rr_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4,
  parameter int HW       = 3,
  parameter int IDW      = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
`ifdef ONEHOT_ARB_LOCK_EN
  input  logic           lock,
`endif
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   ptr,
  output logic           dbg_state
);

  // Handshake: req[i] is a level request; gnt[i] high means requester i owns the resource
  // that cycle. A requester drops req[i] to release; the grant ends on the following edge.

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           valid_q;
  logic [IDW-1:0] id_q;

  // First set bit of r at or above the pointer position, wrapping N-1 -> 0.
  function automatic logic [N-1:0] pick(input logic [N-1:0] p, input logic [N-1:0] r);
    logic found;
    int   j;
    pick  = '0;
    found = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (p[IDW'(s)]) begin
        for (int k = 0; k < N; k++) begin
          j = (s + k) % N;
          if (!found && r[IDW'(j)]) begin
            pick[IDW'(j)] = 1'b1;
            found         = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic logic [IDW-1:0] enc(input logic [N-1:0] v);
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (v[IDW'(i)]) enc = enc | IDW'(i);
    end
  endfunction

  logic          owner_req;
  logic          below_max;
  logic          keep;
  logic [N-1:0]  ptr_rot;

  assign owner_req = |(req & gnt_q);
  assign below_max = (hold_q < HW'(MAX_HOLD));
  assign ptr_rot   = {gnt_q[N-2:0], gnt_q[N-1]};
`ifdef ONEHOT_ARB_LOCK_EN
  assign keep      = owner_req && (below_max || lock);
`else
  assign keep      = owner_req && below_max;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          gnt_d   = pick(ptr_q, req);
          hold_d  = HW'(1);
          state_d = GRANT;
        end else begin
          gnt_d  = '0;
          hold_d = '0;
        end
      end
      GRANT: begin
        if (keep) begin
          // Saturates at MAX_HOLD while locked.
          if (below_max) hold_d = hold_q + HW'(1);
        end else begin
          ptr_d = ptr_rot;
          if (en && (|req)) begin
            gnt_d  = pick(ptr_rot, req);
            hold_d = HW'(1);
          end else begin
            gnt_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= N'(1);
      hold_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      valid_q <= |gnt_d;
      id_q    <= enc(gnt_d);
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;
  assign ptr       = ptr_q;
  assign dbg_state = (state_q == GRANT);

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed bench for onehot_rr_arbiter: reset, single grant, rotation, wrap, en gating,
// async reset mid-grant, timeout re-grant and (with ONEHOT_ARB_LOCK_EN) lock hold.
module tb_onehot_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic [7:0] ptr;
  logic       dbg_state;
`ifdef ONEHOT_ARB_LOCK_EN
  logic       lock;
`endif

  int total;
  int passed;

  onehot_rr_arbiter #(.N(8), .MAX_HOLD(4), .HW(3), .IDW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
`ifdef ONEHOT_ARB_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .ptr       (ptr),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_grant(input string tag, input logic [7:0] eg, input logic [7:0] ep);
    logic [7:0] eid;
    eid = 8'd0;
    for (int i = 0; i < 8; i++) if (eg[i]) eid = 8'(i);
    chk({tag, "_gnt"}, gnt, eg);
    chk({tag, "_vld"}, {7'd0, gnt_valid}, {7'd0, |eg});
    chk({tag, "_id"}, {5'd0, gnt_id}, eid);
    chk({tag, "_ptr"}, ptr, ep);
  endtask

  // invariants sampled every cycle out of reset
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic [7:0] iid;
      iid = 8'd0;
      for (int i = 0; i < 8; i++) if (gnt[i]) iid = 8'(i);
      chk("inv_onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
      chk("inv_valid", {7'd0, gnt_valid}, {7'd0, |gnt});
      chk("inv_id", {5'd0, gnt_id}, iid);
      chk("inv_ptr_onehot", {7'd0, $onehot(ptr)}, 8'd1);
    end
  end

  initial begin
    logic [7:0] e;
    total  = 0;
    passed = 0;
    rst    = 1'b0;
    en     = 1'b0;
    req    = 8'h00;
`ifdef ONEHOT_ARB_LOCK_EN
    lock   = 1'b0;
`endif

    // reset then idle
    tick(); tick();
    chk_grant("rst", 8'h00, 8'h01);
    chk("rst_state", {7'd0, dbg_state}, 8'd0);
    rst = 1'b1;
    tick(); tick();
    chk_grant("idle", 8'h00, 8'h01);

    // single request, dropped after two granted cycles
    en = 1'b1; req = 8'h04;
    tick();
    chk_grant("single1", 8'h04, 8'h01);
    chk("single_state", {7'd0, dbg_state}, 8'd1);
    tick();
    chk_grant("single2", 8'h04, 8'h01);
    req = 8'h00;
    tick();
    chk_grant("single_rel", 8'h00, 8'h08);

    // rotation with all requesting, 4 cycles each, back-to-back
    rst = 1'b0; tick(); rst = 1'b1;
    req = 8'hFF;
    tick();
    for (int g = 0; g < 9; g++) begin
      e = 8'd1 << (g % 8);
      for (int c = 0; c < 4; c++) begin
        chk_grant("rot", e, e);
        tick();
      end
    end
    chk_grant("rot_end", 8'h02, 8'h02);

    // priority wrap from ptr = bit 7
    rst = 1'b0; tick(); rst = 1'b1;
    req = 8'h40;
    tick();
    chk_grant("wrap_g6", 8'h40, 8'h01);
    req = 8'h00;
    tick();
    chk_grant("wrap_ptr7", 8'h00, 8'h80);
    req = 8'h03;
    tick();
    chk_grant("wrap_b0", 8'h01, 8'h80);
    tick(); tick(); tick();
    chk_grant("wrap_b0_last", 8'h01, 8'h80);
    tick();
    chk_grant("wrap_b1", 8'h02, 8'h02);
    req = 8'h00;
    tick();
    chk_grant("wrap_rel", 8'h00, 8'h04);

    // en gating
    en = 1'b0; req = 8'h10;
    tick(); tick();
    chk_grant("en_off", 8'h00, 8'h04);
    en = 1'b1;
    tick();
    chk_grant("en_on", 8'h10, 8'h04);
    en = 1'b0;
    tick();
    chk_grant("en_drop_hold", 8'h10, 8'h04);
    req = 8'h00;
    tick();
    chk_grant("en_drop_rel", 8'h00, 8'h20);
    req = 8'h10;
    tick();
    chk_grant("en_idle", 8'h00, 8'h20);
    chk("en_idle_state", {7'd0, dbg_state}, 8'd0);

    // async reset mid-grant
    en = 1'b1; req = 8'h20;
    tick();
    chk_grant("pre_arst", 8'h20, 8'h20);
    #2 rst = 1'b0;
    #1 chk_grant("arst", 8'h00, 8'h01);
    tick();
    req = 8'h00; rst = 1'b1;
    tick();
    chk_grant("post_arst", 8'h00, 8'h01);

    // timeout with a sole requester: re-granted with the pointer moved past it
    req = 8'h08;
    tick();
    chk_grant("to1", 8'h08, 8'h01);
    tick(); tick(); tick();
    chk_grant("to4", 8'h08, 8'h01);
    tick();
    chk_grant("to_regrant", 8'h08, 8'h10);
    req = 8'h00;
    tick();
    chk_grant("to_rel", 8'h00, 8'h10);

`ifdef ONEHOT_ARB_LOCK_EN
    // lock suppresses the timeout; releasing lock at saturation times out next edge
    lock = 1'b1; req = 8'h08;
    tick();
    for (int c = 0; c < 7; c++) begin
      chk_grant("lock_hold", 8'h08, 8'h10);
      tick();
    end
    lock = 1'b0;
    tick();
    chk_grant("lock_off_regrant", 8'h08, 8'h10);
    req = 8'h00;
    tick();
    chk_grant("lock_rel", 8'h00, 8'h10);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource (e.g. one-hot counter / shared datapath slot) among N requesters.
- Rotating priority held as a one-hot pointer, advanced like a one-hot ring counter after every grant release.
- Grant is one-hot, registered, and bounded by a per-grant hold limit.
- Sits between requesting blocks and the shared resource; `gnt` drives the resource select.

Parameters:
- N, 8, number of requesters (N >= 2).
- MAX_HOLD, 4, maximum consecutive cycles one owner may hold the grant (>= 1).
- HW, 3, hold counter width; must satisfy 2^HW > MAX_HOLD.
- IDW, 3, width of `gnt_id`, equal to clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; gates new grants only.
- req  input  N  request vector; bit i high = requester i wants the resource.
- gnt  output  N  one-hot grant (all zero when idle), registered.
- gnt_valid  output  1  high when `gnt` is nonzero, registered.
- gnt_id  output  IDW  binary index of the granted requester; 0 when idle.
- ptr  output  N  one-hot priority pointer, for debug/visibility.

Behaviour:
- Reset (rst = 0, asynchronous): `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0, `ptr` = 1 (bit 0), hold_cnt = 0, state = IDLE.
- States are IDLE and GRANT.
- Selection function: the first set bit of `req` found searching from the `ptr` position upward, wrapping from bit N-1 to bit 0.
- IDLE:
  - If en = 1 and |req = 1 on edge k, `gnt` becomes the selected one-hot on edge k; the grant is visible from cycle k+1 (latency 1).
  - hold_cnt = 1; state -> GRANT.
  - Otherwise stay in IDLE with outputs 0.
- GRANT, owner o, continue: req[o] = 1 and hold_cnt < MAX_HOLD -> keep `gnt`, hold_cnt++.
- GRANT, release: req[o] = 0, or hold_cnt == MAX_HOLD, in the same sampled cycle.
  - Both conditions together count as a single release.
  - `ptr` <= rotl(one-hot of o), i.e. o+1 mod N.
  - Re-arbitrate on the same edge using the new `ptr` and the current `req`.
  - If en = 1 and a request exists: grant the winner back-to-back with no idle cycle; hold_cnt = 1; stay in GRANT.
  - Otherwise: `gnt` = 0, state -> IDLE.
- On timeout, the owner is lowest priority for the next grant; it is re-granted only if it is the sole requester.
- `ptr` changes only on release, never in IDLE.
- en = 0 during GRANT: the current grant continues until release, then the block goes to IDLE.
- Requests that drop before being granted are simply not selected; there is no request latching.
- Invariants, checked every cycle:
  - `gnt` is one-hot or zero.
  - `gnt_valid` == |gnt.
  - `gnt_id` is consistent with `gnt`.
  - `ptr` is always exactly one-hot.
- Reset asserted mid-grant: all outputs clear immediately; `ptr` returns to bit 0.

Optional Feature:
- Macro: ONEHOT_ARB_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - While in GRANT with lock = 1, the MAX_HOLD timeout is suppressed; hold_cnt saturates at MAX_HOLD.
  - Release occurs only when req[o] = 0.
  - `lock` is ignored in IDLE.
- Not defined: no `lock` port; the timeout always applies.

Test Plan:
- Reset then idle: hold rst = 0 for 2 cycles, then release with req = 0 -> gnt = 0, gnt_valid = 0, ptr = 8'b00000001 throughout.
- Single request: req = 8'b00000100, en = 1, dropped after 2 granted cycles -> gnt = 8'b00000100 from the next cycle, gnt_id = 2, then gnt = 0 and ptr = 8'b00001000.
- Rotation: req = 8'hFF held, en = 1, MAX_HOLD = 4 -> grants 0,1,2,…,7,0 in order, each lasting 4 cycles, back-to-back with no gap.
- Priority wrap: ptr = 8'b10000000 (reached after a bit-6 grant), req = 8'b00000011 -> grant bit 0 first, then bit 1.
- en gating: en = 0 with req = 8'h10 -> no grant. Raise en -> grant bit 4 next cycle. Drop en mid-grant -> the grant holds until req[4] drops, then IDLE.
- Async reset mid-grant: assert rst = 0 between clock edges while gnt = 8'h20 -> gnt = 0 immediately, ptr = 8'h01; with ONEHOT_ARB_LOCK_EN and lock = 1, a single requester holds for more than MAX_HOLD cycles.
